audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
Playback-side sink for the 16-bit samples produced by the waveform music generator. It accepts stereo PCM samples through a valid/ready handshake and serializes them in I2S format. It also generates the master, bit and word clocks for the Pmod I2S2 DAC output stage. It sits between the music/sound-effect mixer and the board audio pins, all in the 100 MHz system domain.

Parameters:
CNT_W, 11, width of the frame counter; one LRCK frame is 2^CNT_W clk cycles (2048, giving 48.828 kHz).
DATA_W, 16, sample width in bits; signed two's complement.

Ports:
clk  input  1  100 MHz system clock
rst  input  1  synchronous, active-high reset
en  input  1  1 = transmit samples; 0 = mute (clocks keep running, data forced to 0)
in_left  input  DATA_W  left-channel sample
in_right  input  DATA_W  right-channel sample
in_valid  input  1  sample pair present
in_ready  output  1  holding buffer empty; pair accepted on in_valid & in_ready
frame_start  output  1  one-cycle pulse when a new frame is loaded into the shifter
underrun  output  1  one-cycle pulse when a frame starts with the holding buffer empty
i2s_mclk  output  1  master clock, clk/4 = 25 MHz
i2s_sclk  output  1  bit clock, clk/32 = 3.125 MHz
i2s_lrck  output  1  word clock, clk/2048; 0 = left, 1 = right
i2s_sdin  output  1  serial data to DAC

Behaviour:
- Reset values: cnt=0; mclk=sclk=lrck=sdin=0; in_ready=1; holding buffer empty; shift registers=0; last-sample registers=0; frame_start=0; underrun=0.
- Frame counter cnt[CNT_W-1:0]:
  - Free-running; increments every clk and wraps 2047->0.
  - Runs regardless of en.
- Clock outputs are taken directly from counter register bits: mclk=cnt[1], sclk=cnt[4], lrck=cnt[10].
- Slot numbering:
  - Channel = cnt[10]; slot k = cnt[9:5], range 0..31.
  - Each slot is one sclk period (32 clk).
- Data placement (I2S, one-bit delay):
  - Slot 0 is 0.
  - Slots 1..16 carry sample bits 15..0, MSB first.
  - Slots 17..31 are 0.
- sdin timing:
  - sdin changes only on the clk edge where sclk falls (cnt[4:0] goes 31->0).
  - sdin is stable for the whole high phase of sclk.
- Holding buffer:
  - One stereo entry.
  - When in_valid & in_ready, the pair is captured and the buffer becomes full; in_ready=0 from the next cycle.
- Frame load (the cycle in which cnt becomes 0):
  - Buffer full: copy the pair to the left/right shift registers and to the last-sample registers; buffer becomes empty; in_ready=1 from the next cycle.
  - Buffer empty: reload last-sample registers into the shifters and pulse underrun for 1 cycle.
  - frame_start pulses for 1 cycle at every load in either case.
- Simultaneous capture and load: if in_valid & in_ready in the same cycle as a load with an empty buffer:
  - The underrun path is taken.
  - The new pair is captured into the buffer and used at the next frame.
- Mute: en=0 forces the shifters to load 0 at each frame. The handshake still consumes pairs, so the upstream generator does not stall. Muting takes effect from the next frame boundary, never mid-word.
- Latency: a pair accepted at least 1 cycle before a frame load reaches sdin MSB 32 clk after the load (left) and 1056 clk after the load (right).
- Reset mid-frame: every register returns to its reset value on the next clk. Clocks restart from phase 0, giving a clean LRCK low edge.

Test Plan:
- Reset then idle 4096 cycles -> mclk period 4, sclk period 32, lrck period 2048 (50% duty); underrun pulses at cnt=0 of each frame; sdin=0 throughout.
- Present L=16'hA5C3, R=16'h8001 before the first frame -> left slots 1..16 carry 1010_0101_1100_0011, right slots carry 1000_0000_0000_0001; slots 0 and 17..31 are 0; frame_start pulse; no underrun.
- Hold in_valid high with an incrementing pair each accept -> exactly one accept per 2048 cycles; in_ready low between loads; no underrun; sample order preserved.
- Supply one pair (L=16'h7FFF, R=16'h0000), then stop -> the next frame repeats 7FFF/0000 with an underrun pulse.
- Drive in_valid & in_ready on the same cycle as an empty-buffer load -> underrun pulses; the new pair appears on the following frame.
- Drop en mid-frame while sending 16'hFFFF -> the current frame completes with FFFF; the next frame is all zeros. Assert rst at cnt=700 -> all outputs 0 next cycle and cnt restarts at 0.

Source files
------------

// File: rtl/audio_i2s_tx_if.sv
// Stereo PCM sample handshake between the mixer and the I2S transmitter.
// A pair transfers on in_valid & in_ready; the master holds data while in_valid is high.
interface audio_i2s_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_left, output in_right, output in_valid, input in_ready);
  modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S transmitter with MCLK/SCLK/LRCK generation; left MSB reaches sdin 32 clk after a frame load, right 1056.
// One-entry holding buffer: in_ready drops after an accept and returns one cycle after the next frame load.
module audio_i2s_tx #(
  parameter int CNT_W  = 11,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  audio_i2s_tx_if.slave         bus,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  i2s_mclk,
  output logic                  i2s_sclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdin
);

  localparam logic [4:0] SLOT_LAST = 5'(DATA_W);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_full;
  logic [DATA_W-1:0] r_buf_l, r_buf_r;
  logic [DATA_W-1:0] r_last_l, r_last_r;
  logic [DATA_W-1:0] r_sh_l, r_sh_r;
  logic              r_frame_start, r_underrun, r_sdin;

  logic              w_load, w_acc, w_bit_edge, w_data_slot, w_chan;
  logic [CNT_W-6:0]  w_hi_nxt;
  logic [4:0]        w_slot;

  assign w_load     = &r_cnt;
  assign w_acc      = bus.in_valid & ~r_full;
  assign w_bit_edge = &r_cnt[4:0];
  // Channel and slot that begin on the coming sclk falling edge.
  assign w_hi_nxt    = r_cnt[CNT_W-1:5] + {{(CNT_W-6){1'b0}}, 1'b1};
  assign w_chan      = w_hi_nxt[CNT_W-6];
  assign w_slot      = w_hi_nxt[4:0];
  assign w_data_slot = (w_slot != 5'd0) && (w_slot <= SLOT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_full        <= 1'b0;
      r_buf_l       <= '0;
      r_buf_r       <= '0;
      r_last_l      <= '0;
      r_last_r      <= '0;
      r_sh_l        <= '0;
      r_sh_r        <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_sdin        <= 1'b0;
    end else begin
      r_cnt         <= r_cnt + 1'b1;
      r_frame_start <= w_load;
      r_underrun    <= w_load & ~r_full;

      if (w_load && r_full) begin
        r_last_l <= r_buf_l;
        r_last_r <= r_buf_r;
        r_sh_l   <= en ? r_buf_l : '0;
        r_sh_r   <= en ? r_buf_r : '0;
        r_full   <= 1'b0;
      end else if (w_load) begin
        r_sh_l <= en ? r_last_l : '0;
        r_sh_r <= en ? r_last_r : '0;
      end else if (w_bit_edge && w_data_slot) begin
        if (w_chan) r_sh_r <= {r_sh_r[DATA_W-2:0], 1'b0};
        else        r_sh_l <= {r_sh_l[DATA_W-2:0], 1'b0};
      end

      // Only possible while empty, so it never collides with the load clearing r_full.
      if (w_acc) begin
        r_buf_l <= bus.in_left;
        r_buf_r <= bus.in_right;
        r_full  <= 1'b1;
      end

      if (w_bit_edge)
        r_sdin <= w_data_slot ? (w_chan ? r_sh_r[DATA_W-1] : r_sh_l[DATA_W-1]) : 1'b0;
    end
  end

  assign bus.in_ready = ~r_full;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;
  assign i2s_mclk     = r_cnt[1];
  assign i2s_sclk     = r_cnt[4];
  assign i2s_lrck     = r_cnt[CNT_W-1];
  assign i2s_sdin     = r_sdin;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: clock phases, frame data, handshake pacing, underrun, mute and reset.
module tb_audio_i2s_tx;

  logic clk, rst, en;
  logic frame_start, underrun, i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdin;
  int   n_checks, n_fail, cyc;

  audio_i2s_tx_if ifc ();

  audio_i2s_tx dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bus         (ifc),
    .frame_start (frame_start),
    .underrun    (underrun),
    .i2s_mclk    (i2s_mclk),
    .i2s_sclk    (i2s_sclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_sdin    (i2s_sdin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a pair and return at the negedge after it has been accepted.
  task automatic push(input logic [15:0] l, input logic [15:0] r, output int acc_cyc, output logic ok);
    int n;
    ifc.in_left  = l;
    ifc.in_right = r;
    ifc.in_valid = 1'b1;
    n = 0;
    while (ifc.in_ready !== 1'b1 && n < 4200) begin
      @(negedge clk);
      n++;
    end
    ok      = (ifc.in_ready === 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  // Wait for the next frame_start and record one full frame of sdin.
  task automatic capture(output logic [15:0] l, output logic [15:0] r, output logic uf,
                         output int bad, output logic found);
    int   i, k;
    logic prev;
    found = 1'b0;
    i = 0;
    l = 'x;
    r = 'x;
    uf = 1'bx;
    bad = 0;
    while (!found && i < 4200) begin
      @(negedge clk);
      i++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    if (found) begin
      uf = underrun;
      l = '0;
      r = '0;
      prev = i2s_sdin;
      for (int c = 0; c < 2048; c++) begin
        if (c > 0) @(negedge clk);
        if ((c % 32) != 0 && i2s_sdin !== prev) bad++;
        prev = i2s_sdin;
        if ((c % 32) == 16) begin
          k = (c / 32) % 32;
          if (k >= 1 && k <= 16) begin
            if (c < 1024) l[16-k] = i2s_sdin;
            else          r[16-k] = i2s_sdin;
          end else if (i2s_sdin !== 1'b0) begin
            bad++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdin} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_clocks got %b want 0000", {i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdin}); end
    n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got %b want 1", ifc.in_ready); end
    n_checks++; if ({frame_start, underrun} !== 2'b00) begin n_fail++;
      $display("FAIL reset_pulses got %b want 00", {frame_start, underrun}); end
  endtask

  // Continues from the reset negedge left by test_reset (counter at 0).
  task automatic test_idle_clocks();
    int e_m, e_s, e_l, e_d, e_u;
    e_m = 0; e_s = 0; e_l = 0; e_d = 0; e_u = 0;
    for (int n = 0; n < 4096; n++) begin
      if (n > 0) @(negedge clk);
      if (i2s_mclk !== 1'((n / 2) % 2))     e_m++;
      if (i2s_sclk !== 1'((n / 16) % 2))    e_s++;
      if (i2s_lrck !== 1'((n / 1024) % 2))  e_l++;
      if (i2s_sdin !== 1'b0)                e_d++;
      if (underrun !== 1'(n == 2048) || frame_start !== 1'(n == 2048)) e_u++;
    end
    n_checks++; if (e_m != 0) begin n_fail++; $display("FAIL idle_mclk got %0d bad cycles want 0", e_m); end
    n_checks++; if (e_s != 0) begin n_fail++; $display("FAIL idle_sclk got %0d bad cycles want 0", e_s); end
    n_checks++; if (e_l != 0) begin n_fail++; $display("FAIL idle_lrck got %0d bad cycles want 0", e_l); end
    n_checks++; if (e_d != 0) begin n_fail++; $display("FAIL idle_sdin got %0d bad cycles want 0", e_d); end
    n_checks++; if (e_u != 0) begin n_fail++; $display("FAIL idle_underrun got %0d bad cycles want 0", e_u); end
  endtask

  task automatic test_sample();
    logic [15:0] l, r; logic uf, ok, fnd; int bad, t;
    do_reset();
    push(16'hA5C3, 16'h8001, t, ok);
    ifc.in_valid = 1'b0;
    capture(l, r, uf, bad, fnd);
    n_checks++; if (fnd !== 1'b1) begin n_fail++; $display("FAIL sample_frame_start got %b want 1", fnd); end
    n_checks++; if (l !== 16'hA5C3) begin n_fail++; $display("FAIL sample_left got %h want a5c3", l); end
    n_checks++; if (r !== 16'h8001) begin n_fail++; $display("FAIL sample_right got %h want 8001", r); end
    n_checks++; if (uf !== 1'b0) begin n_fail++; $display("FAIL sample_underrun got %b want 0", uf); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sample_framing got %0d errors want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] l[3], r[3]; logic uf[3], fnd[3], ok[3]; int bad[3], t[3];
    do_reset();
    fork
      begin
        for (int i = 0; i < 3; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i), t[i], ok[i]);
        ifc.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) capture(l[i], r[i], uf[i], bad[i], fnd[i]);
      end
    join
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (l[i] !== 16'h1000 + 16'(i) || r[i] !== 16'h2000 + 16'(i)) begin n_fail++;
        $display("FAIL b2b_data[%0d] got %h/%h want %h/%h", i, l[i], r[i], 16'h1000 + 16'(i), 16'h2000 + 16'(i)); end
      n_checks++; if (uf[i] !== 1'b0 || bad[i] != 0) begin n_fail++;
        $display("FAIL b2b_underrun_framing[%0d] got uf=%b bad=%0d want 0/0", i, uf[i], bad[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++; if (t[i] - t[i-1] != 2048) begin n_fail++;
        $display("FAIL b2b_accept_spacing[%0d] got %0d want 2048", i, t[i] - t[i-1]); end
    end
  endtask

  task automatic test_underrun_repeat();
    logic [15:0] l, r; logic uf, ok, fnd; int bad, t;
    do_reset();
    push(16'h7FFF, 16'h0000, t, ok);
    ifc.in_valid = 1'b0;
    capture(l, r, uf, bad, fnd);
    n_checks++; if (l !== 16'h7FFF || r !== 16'h0000 || uf !== 1'b0) begin n_fail++;
      $display("FAIL repeat_first got %h/%h uf=%b want 7fff/0000 uf=0", l, r, uf); end
    capture(l, r, uf, bad, fnd);
    n_checks++; if (l !== 16'h7FFF || r !== 16'h0000) begin n_fail++;
      $display("FAIL repeat_second got %h/%h want 7fff/0000", l, r); end
    n_checks++; if (uf !== 1'b1) begin n_fail++; $display("FAIL repeat_underrun got %b want 1", uf); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] l, r; logic uf, fnd; int bad;
    do_reset();
    repeat (2047) @(negedge clk);
    ifc.in_left  = 16'h1234;
    ifc.in_right = 16'h5678;
    ifc.in_valid = 1'b1;
    fork
      capture(l, r, uf, bad, fnd);
      begin
        @(negedge clk);
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++;
          $display("FAIL simul_captured got in_ready=%b want 0", ifc.in_ready); end
      end
    join
    n_checks++; if (uf !== 1'b1 || l !== 16'h0000 || r !== 16'h0000) begin n_fail++;
      $display("FAIL simul_underrun_frame got %h/%h uf=%b want 0000/0000 uf=1", l, r, uf); end
    capture(l, r, uf, bad, fnd);
    n_checks++; if (l !== 16'h1234 || r !== 16'h5678 || uf !== 1'b0) begin n_fail++;
      $display("FAIL simul_next_frame got %h/%h uf=%b want 1234/5678 uf=0", l, r, uf); end
  endtask

  task automatic test_mute();
    logic [15:0] l[2], r[2]; logic uf[2], fnd[2], ok; int bad[2], t;
    do_reset();
    fork
      begin
        push(16'hFFFF, 16'hFFFF, t, ok);
        push(16'hFFFF, 16'hFFFF, t, ok);
        ifc.in_valid = 1'b0;
        repeat (500) @(negedge clk);
        en = 1'b0;
      end
      begin
        capture(l[0], r[0], uf[0], bad[0], fnd[0]);
        capture(l[1], r[1], uf[1], bad[1], fnd[1]);
      end
    join
    en = 1'b1;
    n_checks++; if (l[0] !== 16'hFFFF || r[0] !== 16'hFFFF || bad[0] != 0) begin n_fail++;
      $display("FAIL mute_current_frame got %h/%h bad=%0d want ffff/ffff bad=0", l[0], r[0], bad[0]); end
    n_checks++; if (l[1] !== 16'h0000 || r[1] !== 16'h0000 || uf[1] !== 1'b0) begin n_fail++;
      $display("FAIL mute_next_frame got %h/%h uf=%b want 0000/0000 uf=0", l[1], r[1], uf[1]); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] l, r; logic uf, ok, fnd; int bad, t;
    do_reset();
    push(16'hAAAA, 16'h5555, t, ok);
    ifc.in_valid = 1'b0;
    repeat (699) @(negedge clk);
    n_checks++; if (ifc.in_ready !== 1'b0 || i2s_sclk !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_before got rdy=%b sclk=%b want 0/1", ifc.in_ready, i2s_sclk); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdin, frame_start, underrun} !== 6'b0) begin n_fail++;
      $display("FAIL rstmid_outputs got %b want 000000",
               {i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdin, frame_start, underrun}); end
    n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_in_ready got %b want 1", ifc.in_ready); end
    rst = 1'b0;
    repeat (1023) @(negedge clk);
    n_checks++; if (i2s_lrck !== 1'b0) begin n_fail++; $display("FAIL rstmid_lrck_1023 got %b want 0", i2s_lrck); end
    @(negedge clk);
    n_checks++; if (i2s_lrck !== 1'b1) begin n_fail++; $display("FAIL rstmid_lrck_1024 got %b want 1", i2s_lrck); end
    capture(l, r, uf, bad, fnd);
    n_checks++; if (l !== 16'h0000 || r !== 16'h0000 || uf !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_cleared got %h/%h uf=%b want 0000/0000 uf=1", l, r, uf); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    en  = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_left  = '0;
    ifc.in_right = '0;
    test_reset();
    test_idle_clocks();
    test_sample();
    test_back_to_back();
    test_underrun_repeat();
    test_simultaneous();
    test_mute();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
